// File: rtl/inst_fetch_buffer.sv
// inst_fetch_buffer: show-ahead fetch-to-decode FIFO presenting up to two oldest instructions per cycle
module inst_fetch_buffer #(
  parameter int DEPTH       = 8,
  parameter int ALMOST_FULL = 6,
  parameter int ADDR_W      = 32,
  parameter int INST_W      = 32,
  parameter int ECODE_W     = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     enq_valid,
  input  logic [ADDR_W-1:0]        enq_pc,
  input  logic [INST_W-1:0]        enq_inst,
  input  logic                     enq_exc,
  input  logic [ECODE_W-1:0]       enq_ecode,
  output logic                     enq_ready,
  output logic                     stall_o,
  output logic                     deq_valid_1,
  output logic                     deq_valid_2,
  output logic [ADDR_W-1:0]        deq_pc_1,
  output logic [ADDR_W-1:0]        deq_pc_2,
  output logic [INST_W-1:0]        deq_inst_1,
  output logic [INST_W-1:0]        deq_inst_2,
  output logic                     deq_exc_1,
  output logic                     deq_exc_2,
  output logic [ECODE_W-1:0]       deq_ecode_1,
  output logic [ECODE_W-1:0]       deq_ecode_2,
  input  logic                     deq_ready_1,
  input  logic                     deq_ready_2,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [ADDR_W-1:0]  r_pc    [DEPTH];
  logic [INST_W-1:0]  r_inst  [DEPTH];
  logic               r_exc   [DEPTH];
  logic [ECODE_W-1:0] r_ecode [DEPTH];
  logic [PW-1:0]      r_head, r_tail;
  logic [CW-1:0]      r_count;
  logic [PW-1:0]      w_head_1;
  logic               w_enq_fire;
  logic [1:0]         w_n;
  assign w_head_1    = r_head + PW'(1);
  assign enq_ready   = r_count < CW'(DEPTH);
  assign stall_o     = r_count >= CW'(ALMOST_FULL);
  assign count       = r_count;
  assign deq_valid_1 = r_count != '0;
  // an excepting head is issued alone so decode never pairs it with a younger instruction
  assign deq_valid_2 = (r_count >= CW'(2)) && !r_exc[r_head];
  assign deq_pc_1    = deq_valid_1 ? r_pc[r_head]      : '0;
  assign deq_inst_1  = deq_valid_1 ? r_inst[r_head]    : '0;
  assign deq_exc_1   = deq_valid_1 ? r_exc[r_head]     : 1'b0;
  assign deq_ecode_1 = deq_valid_1 ? r_ecode[r_head]   : '0;
  assign deq_pc_2    = deq_valid_2 ? r_pc[w_head_1]    : '0;
  assign deq_inst_2  = deq_valid_2 ? r_inst[w_head_1]  : '0;
  assign deq_exc_2   = deq_valid_2 ? r_exc[w_head_1]   : 1'b0;
  assign deq_ecode_2 = deq_valid_2 ? r_ecode[w_head_1] : '0;
  assign w_enq_fire  = enq_valid && enq_ready && !flush;
  assign w_n         = {1'b0, deq_valid_1 && deq_ready_1} + {1'b0, deq_valid_2 && deq_ready_2 && deq_ready_1};
  always_ff @(posedge clk) begin
    if (w_enq_fire) begin
      r_pc[r_tail]    <= enq_pc;
      r_inst[r_tail]  <= enq_inst;
      r_exc[r_tail]   <= enq_exc;
      r_ecode[r_tail] <= enq_ecode;
    end
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(w_n);
      r_tail  <= r_tail + PW'(w_enq_fire);
      r_count <= r_count + CW'(w_enq_fire) - CW'(w_n);
    end
  end
endmodule

// File: tb/tb_inst_fetch_buffer.sv
// tb_inst_fetch_buffer: directed plus random stimulus checked against a queue-based reference model
module tb_inst_fetch_buffer;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exc;
    logic [6:0]  ecode;
  } ent_t;
  logic clk = 0, rst = 1, flush = 0, enq_valid = 0, enq_exc = 0;
  logic [31:0] enq_pc = 0, enq_inst = 0;
  logic [6:0] enq_ecode = 0;
  logic deq_ready_1 = 0, deq_ready_2 = 0;
  logic enq_ready, stall_o, deq_valid_1, deq_valid_2, deq_exc_1, deq_exc_2;
  logic [31:0] deq_pc_1, deq_pc_2, deq_inst_1, deq_inst_2;
  logic [6:0] deq_ecode_1, deq_ecode_2;
  logic [3:0] count;
  int n_cmp = 0, n_err = 0;
  ent_t q[$];
  always #5 clk = ~clk;
  inst_fetch_buffer dut (
    .clk(clk), .rst(rst), .flush(flush), .enq_valid(enq_valid), .enq_pc(enq_pc),
    .enq_inst(enq_inst), .enq_exc(enq_exc), .enq_ecode(enq_ecode), .enq_ready(enq_ready),
    .stall_o(stall_o), .deq_valid_1(deq_valid_1), .deq_valid_2(deq_valid_2),
    .deq_pc_1(deq_pc_1), .deq_pc_2(deq_pc_2), .deq_inst_1(deq_inst_1), .deq_inst_2(deq_inst_2),
    .deq_exc_1(deq_exc_1), .deq_exc_2(deq_exc_2), .deq_ecode_1(deq_ecode_1),
    .deq_ecode_2(deq_ecode_2), .deq_ready_1(deq_ready_1), .deq_ready_2(deq_ready_2),
    .count(count)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic check_model();
    ent_t z, s1, s2;
    bit v1, v2;
    z  = '0;
    v1 = q.size() >= 1;
    v2 = q.size() >= 2 && !q[0].exc;
    s1 = v1 ? q[0] : z;
    s2 = v2 ? q[1] : z;
    chk("count", 64'(count), 64'(q.size()));
    chk("enq_ready", 64'(enq_ready), 64'(q.size() < 8));
    chk("stall_o", 64'(stall_o), 64'(q.size() >= 6));
    chk("deq_valid_1", 64'(deq_valid_1), 64'(v1));
    chk("deq_valid_2", 64'(deq_valid_2), 64'(v2));
    chk("deq_pc_1", 64'(deq_pc_1), 64'(s1.pc));
    chk("deq_inst_1", 64'(deq_inst_1), 64'(s1.inst));
    chk("deq_exc_1", 64'(deq_exc_1), 64'(s1.exc));
    chk("deq_ecode_1", 64'(deq_ecode_1), 64'(s1.ecode));
    chk("deq_pc_2", 64'(deq_pc_2), 64'(s2.pc));
    chk("deq_inst_2", 64'(deq_inst_2), 64'(s2.inst));
    chk("deq_exc_2", 64'(deq_exc_2), 64'(s2.exc));
    chk("deq_ecode_2", 64'(deq_ecode_2), 64'(s2.ecode));
  endtask
  // check current outputs, advance the model by the driven inputs, then clock
  task automatic cyc();
    int sz, n;
    bit v1, v2;
    check_model();
    sz = q.size();
    v1 = sz >= 1;
    v2 = sz >= 2 && !q[0].exc;
    if (flush) q.delete();
    else begin
      n = int'(v1 && deq_ready_1) + int'(v2 && deq_ready_2 && deq_ready_1);
      repeat (n) void'(q.pop_front());
      if (enq_valid && sz >= 8) $display("note: upstream enqueue of pc %h dropped while buffer full", enq_pc);
      else if (enq_valid) q.push_back('{enq_pc, enq_inst, enq_exc, enq_ecode});
    end
    @(posedge clk);
    #1;
  endtask
  task automatic drive_enq(input logic v, input logic [31:0] pc, input logic e, input logic [6:0] ec);
    enq_valid = v;
    enq_pc    = pc;
    enq_inst  = pc ^ 32'hA5A5_0000;
    enq_exc   = e;
    enq_ecode = ec;
  endtask
  initial begin
    @(posedge clk);
    #1;
    rst = 0;
    chk("reset_count", 64'(count), 0);
    chk("reset_enq_ready", 64'(enq_ready), 1);
    chk("reset_valid_1", 64'(deq_valid_1), 0);
    chk("reset_pc_1", 64'(deq_pc_1), 0);
    for (int i = 0; i < 3; i++) begin
      drive_enq(1, 32'h1c00_0000 + 32'(4 * i), 0, 0);
      cyc();
    end
    drive_enq(0, 0, 0, 0);
    chk("t1_count", 64'(count), 3);
    chk("t1_pc_1", 64'(deq_pc_1), 64'h1c00_0000);
    chk("t1_pc_2", 64'(deq_pc_2), 64'h1c00_0004);
    chk("t1_valid_2", 64'(deq_valid_2), 1);
    deq_ready_1 = 1; deq_ready_2 = 1;
    cyc();
    deq_ready_1 = 0; deq_ready_2 = 0;
    chk("t2_count", 64'(count), 1);
    chk("t2_pc_1", 64'(deq_pc_1), 64'h1c00_0008);
    chk("t2_valid_2", 64'(deq_valid_2), 0);
    for (int i = 0; i < 7; i++) begin
      drive_enq(1, 32'h1c00_0100 + 32'(4 * i), 0, 0);
      if (count == 6) chk("t3_stall_at_6", 64'(stall_o), 1);
      cyc();
    end
    chk("t3_count_full", 64'(count), 8);
    chk("t3_enq_ready_full", 64'(enq_ready), 0);
    drive_enq(1, 32'h1c00_0200, 0, 0);
    deq_ready_1 = 1; deq_ready_2 = 1;
    cyc();
    deq_ready_1 = 0; deq_ready_2 = 0;
    drive_enq(0, 0, 0, 0);
    chk("t3_count_after", 64'(count), 6);
    chk("t3_enq_ready_after", 64'(enq_ready), 1);
    flush = 1;
    cyc();
    flush = 0;
    drive_enq(1, 32'h1c00_0300, 1, 7'h08);
    cyc();
    drive_enq(1, 32'h1c00_0304, 0, 0);
    cyc();
    drive_enq(0, 0, 0, 0);
    chk("t4_valid_1", 64'(deq_valid_1), 1);
    chk("t4_exc_1", 64'(deq_exc_1), 1);
    chk("t4_ecode_1", 64'(deq_ecode_1), 64'h08);
    chk("t4_valid_2", 64'(deq_valid_2), 0);
    cyc();
    deq_ready_1 = 1; deq_ready_2 = 1;
    cyc();
    deq_ready_1 = 0; deq_ready_2 = 0;
    chk("t4_pc_1_next", 64'(deq_pc_1), 64'h1c00_0304);
    for (int i = 0; i < 4; i++) begin
      drive_enq(1, 32'h1c00_0400 + 32'(4 * i), 0, 0);
      cyc();
    end
    chk("t5_count_5", 64'(count), 5);
    flush = 1; deq_ready_1 = 1; deq_ready_2 = 1;
    drive_enq(1, 32'h1c00_0500, 0, 0);
    cyc();
    flush = 0; deq_ready_1 = 0; deq_ready_2 = 0;
    chk("t5_count_0", 64'(count), 0);
    chk("t5_valid_1", 64'(deq_valid_1), 0);
    chk("t5_valid_2", 64'(deq_valid_2), 0);
    drive_enq(1, 32'h1c00_0600, 0, 0);
    cyc();
    drive_enq(0, 0, 0, 0);
    chk("t5_pc_1", 64'(deq_pc_1), 64'h1c00_0600);
    for (int i = 0; i < 200; i++) begin
      drive_enq(1'($urandom_range(0, 9) < 7), $urandom, 1'($urandom_range(0, 7) == 0), 7'($urandom));
      enq_inst    = $urandom;
      deq_ready_1 = 1'($urandom_range(0, 2) != 0);
      deq_ready_2 = 1'($urandom_range(0, 1));
      flush       = 1'($urandom_range(0, 39) == 0);
      cyc();
    end
    drive_enq(0, 0, 0, 0);
    flush = 0; deq_ready_1 = 0; deq_ready_2 = 0;
    cyc();
    check_model();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
